lap_stopwatch: RTL and testbench
================================

# lap_stopwatch

Parametrised stopwatch core generalising the board stopwatch. Adds count-down mode with a preset, a lap-capture buffer of configurable depth, and a programmable tick prescaler. The time register is kept directly as BCD digits, so display decoders attach without division. It sits between the debounced key inputs and the seven-segment/LED drivers on the top level.

## Interface
- `TICK_DIV`, default 1: `clk` cycles per centisecond tick, ≥1.
- `LAP_DEPTH`, default 8: lap buffer entries, 1..16.
- `LED_WIDTH`, default 10: status chase LEDs.
- `LED_DIV`, default 50: ticks per chase step.
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low.
- `btn_start` in 1: start/stop request. Level, active-high, debounced, asynchronous to `clk`.
- `btn_pause` in 1: pause/resume request. Same signalling as `btn_start`.
- `btn_lap` in 1: lap capture request. Same signalling as `btn_start`.
- `btn_clear` in 1: clear request. Same signalling as `btn_start`.
- `mode_down` in 1: 1 = count down from `preset`.
- `preset` in 24: BCD MM:SS.CC, six 4-bit digits, MSB = tens of minutes.
- `time_bcd` out 24: current time, same format as `preset`.
- `lap_rd_idx` in 4: lap read address.
- `lap_rd_data` out 24: lap entry at `lap_rd_idx`. Combinational read.
- `lap_count` out 5: number of laps stored.
- `lap_full` out 1: `lap_count == LAP_DEPTH`.
- `running` out 1: state is RUN.
- `expired` out 1: state is DONE.
- `led` out `LED_WIDTH`: one-hot chase while RUN or PAUSED, zero otherwise.

## Operation
- Each `btn_*` passes a 2-FF synchroniser and a rising-edge detector, giving a one-cycle command pulse.
- States: IDLE, RUN, PAUSED, DONE.
- Command priority when pulses coincide: clear > start > pause > lap.
- clear, from any state:
  - go to IDLE
  - `time_bcd` = 0
  - `lap_count` = 0
  - prescaler = 0
  - LED position = `LED_WIDTH`-1
- start:
  - IDLE → RUN. In down mode with `time_bcd` == 0, load `preset` first. If `preset` holds an invalid digit (units >9, tens-of-seconds >5), ignore the start and stay IDLE.
  - RUN, PAUSED or DONE → IDLE. Time is held.
- pause: RUN → PAUSED, PAUSED → RUN. Ignored elsewhere.
- lap: in RUN or PAUSED with `lap_full` = 0, write `time_bcd` to entry `lap_count`, then increment `lap_count`. Ignored otherwise.
- `mode_down` is sampled only on the IDLE → RUN transition and latched for the run.
- Tick:
  - Prescaler counts 0..`TICK_DIV`-1, only in RUN.
  - A tick fires when the prescaler is at `TICK_DIV`-1, and the prescaler wraps to 0.
  - The prescaler holds its value in PAUSED.
- Up mode per tick:
  - BCD increment with carries CC 99→00, SS 59→00, MM 99→00.
  - 99:59.99 wraps to 00:00.00 and running continues.
- Down mode per tick:
  - BCD decrement with borrows.
  - A tick that produces 00:00.00 moves to DONE; `time_bcd` holds 00:00.00.
  - Preset 00:00.00 reaches DONE on the first tick.
- LED chase: position decrements every `LED_DIV` ticks, from `LED_WIDTH`-1 down to 0, then back to `LED_WIDTH`-1. Advances only on ticks; frozen in PAUSED.
- `lap_rd_idx` ≥ `lap_count` reads 0.

## Timing
- Reset values: state IDLE; all outputs 0 except `led` = 0 (IDLE).
- Button rise to state change: 3 cycles (2 synchroniser + 1 edge register).
- Tick to `time_bcd` update: 1 cycle, registered.
- With `TICK_DIV` = 1, time advances every cycle in RUN, starting the cycle after entry.
- Lap write and the tick in the same cycle: the lap stores the pre-tick value.
- Lap and clear pulses in the same cycle: clear wins and nothing is written.
- Reset asserted mid-run: all state clears immediately. Releasing reset does not create a pulse for any button already held; edges need a fresh rising level.

## Structure
- Package `stopwatch_pkg`: state enum, `bcd_time_t` (six 4-bit digits), digit limit constants, `BCD_ZERO`.
- Sub-module `bcd_time_counter`: en, up/down, load/clear inputs; outputs next time and a zero flag; cascaded digit carry/borrow.
- Lap buffer is a register array inside `lap_stopwatch`.

## Test plan
- `TICK_DIV`=1, up mode, start, run 6000 cycles → `time_bcd` = 01:00.00; pause for 50 cycles → value unchanged.
- Up mode, force 99:59.99, one tick → 00:00.00 with `running` = 1.
- Down mode, preset 00:01.05, start → DONE after exactly 105 ticks, `expired` = 1, `time_bcd` 0; further ticks change nothing.
- `LAP_DEPTH`=2: laps at 00:00.10, 00:00.20, 00:00.30 → entries 0/1 hold the first two values, `lap_full` = 1, third lap ignored.
- Clear and start pulsing in the same cycle during RUN → IDLE, time 0, `lap_count` 0.
- Preset 00:7A.00 (invalid digit) with start → stays IDLE. Reset asserted mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the lap stopwatch: FSM states, BCD time layout and digit limits.
package stopwatch_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StPaused, StDone} sw_state_e;

  // Digit 5 is tens of minutes, digit 0 is units of centiseconds.
  typedef logic [5:0][3:0] bcd_time_t;

  localparam int unsigned NumDigits = 6;
  localparam bcd_time_t DIGIT_MAX = {4'd9, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};
  localparam bcd_time_t BCD_ZERO  = '0;

  function automatic logic bcd_valid(input bcd_time_t t);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NumDigits; i++) begin
      if (t[i] > DIGIT_MAX[i]) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// Next-value logic for the MM:SS.CC BCD time register with cascaded carry/borrow.
module bcd_time_counter
  import stopwatch_pkg::*;
(
  input  bcd_time_t time_i,
  input  logic      en_i,
  input  logic      up_i,
  input  logic      load_i,
  input  logic      clear_i,
  input  bcd_time_t load_val_i,
  output bcd_time_t time_o,
  output logic      zero_o
);

  logic cy;

  always_comb begin
    time_o = time_i;
    cy     = 1'b1;
    if (clear_i) begin
      time_o = BCD_ZERO;
    end else if (load_i) begin
      time_o = load_val_i;
    end else if (en_i) begin
      if (up_i) begin
        for (int i = 0; i < NumDigits; i++) begin
          if (cy) begin
            if (time_i[i] == DIGIT_MAX[i]) begin
              time_o[i] = 4'd0;
            end else begin
              time_o[i] = time_i[i] + 4'd1;
              cy        = 1'b0;
            end
          end
        end
      end else if (time_i != BCD_ZERO) begin
        // Down count saturates at zero so a zero preset expires without wrapping.
        for (int i = 0; i < NumDigits; i++) begin
          if (cy) begin
            if (time_i[i] == 4'd0) begin
              time_o[i] = DIGIT_MAX[i];
            end else begin
              time_o[i] = time_i[i] - 4'd1;
              cy        = 1'b0;
            end
          end
        end
      end
    end
  end

  assign zero_o = (time_o == BCD_ZERO);

endmodule

// File: rtl/lap_stopwatch.sv
// Stopwatch core: button edge detection, run/pause/done FSM, tick prescaler, lap buffer, LED chase.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 1,
  parameter int unsigned LAP_DEPTH = 8,
  parameter int unsigned LED_WIDTH = 10,
  parameter int unsigned LED_DIV   = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 btn_start,
  input  logic                 btn_pause,
  input  logic                 btn_lap,
  input  logic                 btn_clear,
  input  logic                 mode_down,
  input  logic [23:0]          preset,
  output logic [23:0]          time_bcd,
  input  logic [3:0]           lap_rd_idx,
  output logic [23:0]          lap_rd_data,
  output logic [4:0]           lap_count,
  output logic                 lap_full,
  output logic                 running,
  output logic                 expired,
  output logic [LED_WIDTH-1:0] led
);

  localparam int unsigned PresW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned LedCntW = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
  localparam int unsigned LedPosW = (LED_WIDTH > 1) ? $clog2(LED_WIDTH) : 1;

  // Bit order: {clear, start, pause, lap}
  logic [3:0] btn_raw, sync1_q, sync2_q, edge_q, armed_q, cmd;
  logic [1:0] settle_q;

  assign btn_raw = {btn_clear, btn_start, btn_pause, btn_lap};

  // A button only arms once it has been seen low after reset, so a held key never fires.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      edge_q   <= '0;
      armed_q  <= '0;
      settle_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
      if (settle_q != 2'd2) begin
        settle_q <= settle_q + 2'd1;
      end else begin
        armed_q <= armed_q | ~sync2_q;
      end
    end
  end

  assign cmd = sync2_q & ~edge_q & armed_q;

  logic cmd_clear, cmd_start, cmd_pause, cmd_lap;
  assign cmd_clear = cmd[3];
  assign cmd_start = cmd[2] & ~cmd[3];
  assign cmd_pause = cmd[1] & ~|cmd[3:2];
  assign cmd_lap   = cmd[0] & ~|cmd[3:1];

  sw_state_e            state_q;
  bcd_time_t            time_q, time_next;
  logic                 down_q;
  logic [PresW-1:0]     presc_q;
  logic [LedCntW-1:0]   led_cnt_q;
  logic [LedPosW-1:0]   led_pos_q;
  logic [4:0]           lap_cnt_q;
  bcd_time_t            lap_mem_q [LAP_DEPTH];

  logic tick, need_load, start_ok, cnt_zero, active, lap_we;

  assign tick      = (state_q == StRun) && (presc_q == PresW'(TICK_DIV - 1));
  assign need_load = mode_down && (time_q == BCD_ZERO);
  assign start_ok  = cmd_start && (state_q == StIdle) && (!need_load || bcd_valid(preset));
  assign active    = (state_q == StRun) || (state_q == StPaused);
  assign lap_we    = cmd_lap && active && !lap_full;

  bcd_time_counter u_counter (
    .time_i     (time_q),
    .en_i       (tick),
    .up_i       (!down_q),
    .load_i     (start_ok && need_load),
    .clear_i    (cmd_clear),
    .load_val_i (preset),
    .time_o     (time_next),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      time_q    <= BCD_ZERO;
      down_q    <= 1'b0;
      presc_q   <= '0;
      led_cnt_q <= '0;
      led_pos_q <= LedPosW'(LED_WIDTH - 1);
      lap_cnt_q <= '0;
      for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= BCD_ZERO;
    end else begin
      time_q <= time_next;
      if (cmd_clear) begin
        state_q   <= StIdle;
        presc_q   <= '0;
        led_cnt_q <= '0;
        led_pos_q <= LedPosW'(LED_WIDTH - 1);
        lap_cnt_q <= '0;
      end else begin
        if (tick) begin
          presc_q <= '0;
          if (led_cnt_q == LedCntW'(LED_DIV - 1)) begin
            led_cnt_q <= '0;
            led_pos_q <= (led_pos_q == '0) ? LedPosW'(LED_WIDTH - 1)
                                           : led_pos_q - LedPosW'(1);
          end else begin
            led_cnt_q <= led_cnt_q + LedCntW'(1);
          end
        end else if (state_q == StRun) begin
          presc_q <= presc_q + PresW'(1);
        end

        case (state_q)
          StIdle: begin
            if (start_ok) begin
              state_q <= StRun;
              down_q  <= mode_down;
            end
          end
          StRun: begin
            if (cmd_start)                       state_q <= StIdle;
            else if (cmd_pause)                  state_q <= StPaused;
            else if (tick && down_q && cnt_zero) state_q <= StDone;
          end
          StPaused: begin
            if (cmd_start)      state_q <= StIdle;
            else if (cmd_pause) state_q <= StRun;
          end
          StDone: begin
            if (cmd_start) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase

        // Lap stores the pre-tick value because time_q is sampled before this edge's update.
        if (lap_we) begin
          for (int i = 0; i < LAP_DEPTH; i++) begin
            if (lap_cnt_q == 5'(i)) lap_mem_q[i] <= time_q;
          end
          lap_cnt_q <= lap_cnt_q + 5'd1;
        end
      end
    end
  end

  always_comb begin
    lap_rd_data = '0;
    for (int i = 0; i < LAP_DEPTH; i++) begin
      if ((lap_rd_idx == 4'(i)) && (5'(i) < lap_cnt_q)) lap_rd_data = lap_mem_q[i];
    end
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < LED_WIDTH; i++) begin
      led[i] = active && (led_pos_q == LedPosW'(i));
    end
  end

  assign time_bcd  = time_q;
  assign lap_count = lap_cnt_q;
  assign lap_full  = (lap_cnt_q == 5'(LAP_DEPTH));
  assign running   = (state_q == StRun);
  assign expired   = (state_q == StDone);

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: command vector table plus hand-timed multi-cycle sequences.
module tb_lap_stopwatch;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_start, btn_pause, btn_lap, btn_clear, mode_down;
  logic [23:0] preset;
  logic [23:0] time_bcd;
  logic [3:0]  lap_rd_idx;
  logic [23:0] lap_rd_data;
  logic [4:0]  lap_count;
  logic        lap_full, running, expired;
  logic [3:0]  led;

  int checks   = 0;
  int failures = 0;

  lap_stopwatch #(
    .TICK_DIV  (1),
    .LAP_DEPTH (2),
    .LED_WIDTH (4),
    .LED_DIV   (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_start   (btn_start),
    .btn_pause   (btn_pause),
    .btn_lap     (btn_lap),
    .btn_clear   (btn_clear),
    .mode_down   (mode_down),
    .preset      (preset),
    .time_bcd    (time_bcd),
    .lap_rd_idx  (lap_rd_idx),
    .lap_rd_data (lap_rd_data),
    .lap_count   (lap_count),
    .lap_full    (lap_full),
    .running     (running),
    .expired     (expired),
    .led         (led)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  btn;   // {clear, start, pause, lap}
    logic        md;
    logic [23:0] pre;
    logic [23:0] t;
    logic        run;
    logic        exp;
    logic [4:0]  lc;
    logic        led_on;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds the buttons for three edges: the command takes effect on the third edge.
  task automatic press(input logic [3:0] m);
    {btn_clear, btn_start, btn_pause, btn_lap} = m;
    step(3);
    {btn_clear, btn_start, btn_pause, btn_lap} = 4'b0000;
  endtask

  initial begin
    vecs[0]  = '{4'b1000, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[1]  = '{4'b0100, 1'b1, 24'h000012, 24'h000009, 1'b1, 1'b0, 5'd0, 1'b1};
    vecs[2]  = '{4'b0010, 1'b1, 24'h000012, 24'h000006, 1'b0, 1'b0, 5'd0, 1'b1};
    vecs[3]  = '{4'b0001, 1'b1, 24'h000012, 24'h000006, 1'b0, 1'b0, 5'd1, 1'b1};
    vecs[4]  = '{4'b0010, 1'b1, 24'h000012, 24'h000003, 1'b1, 1'b0, 5'd1, 1'b1};
    vecs[5]  = '{4'b0000, 1'b1, 24'h000012, 24'h000000, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[6]  = '{4'b0001, 1'b1, 24'h000012, 24'h000000, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[7]  = '{4'b0010, 1'b1, 24'h000012, 24'h000000, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[8]  = '{4'b0100, 1'b1, 24'h000012, 24'h000000, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[9]  = '{4'b0100, 1'b0, 24'h000012, 24'h000003, 1'b1, 1'b0, 5'd1, 1'b1};
    vecs[10] = '{4'b0100, 1'b0, 24'h000012, 24'h000006, 1'b0, 1'b0, 5'd1, 1'b0};
    vecs[11] = '{4'b0100, 1'b1, 24'h000012, 24'h000003, 1'b1, 1'b0, 5'd1, 1'b1};
    vecs[12] = '{4'b0000, 1'b0, 24'h000012, 24'h000000, 1'b0, 1'b1, 5'd1, 1'b0};
    vecs[13] = '{4'b1000, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[14] = '{4'b0100, 1'b1, 24'h007A00, 24'h000000, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[15] = '{4'b0100, 1'b1, 24'h006000, 24'h000000, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[16] = '{4'b0100, 1'b0, 24'h000000, 24'h000003, 1'b1, 1'b0, 5'd0, 1'b1};
    vecs[17] = '{4'b0011, 1'b0, 24'h000000, 24'h000006, 1'b0, 1'b0, 5'd0, 1'b1};
    vecs[18] = '{4'b0110, 1'b0, 24'h000000, 24'h000006, 1'b0, 1'b0, 5'd0, 1'b0};
    vecs[19] = '{4'b1000, 1'b0, 24'h000000, 24'h000000, 1'b0, 1'b0, 5'd0, 1'b0};

    reset = 1'b0;
    {btn_clear, btn_start, btn_pause, btn_lap} = 4'b0000;
    mode_down  = 1'b0;
    preset     = '0;
    lap_rd_idx = '0;
    #12;
    chk("rst time", 32'(time_bcd), 32'h0);
    chk("rst running", 32'(running), 32'h0);
    chk("rst expired", 32'(expired), 32'h0);
    chk("rst led", 32'(led), 32'h0);
    chk("rst lap_count", 32'(lap_count), 32'h0);
    chk("rst lap_full", 32'(lap_full), 32'h0);
    chk("rst lap_rd_data", 32'(lap_rd_data), 32'h0);
    reset = 1'b1;
    step(5);

    // Each vector: press for 3 edges, release, wait 3 more, then sample.
    for (int i = 0; i < 20; i++) begin
      mode_down = vecs[i].md;
      preset    = vecs[i].pre;
      press(vecs[i].btn);
      step(3);
      chk($sformatf("v%0d time", i), 32'(time_bcd), 32'(vecs[i].t));
      chk($sformatf("v%0d running", i), 32'(running), 32'(vecs[i].run));
      chk($sformatf("v%0d expired", i), 32'(expired), 32'(vecs[i].exp));
      chk($sformatf("v%0d lap_count", i), 32'(lap_count), 32'(vecs[i].lc));
      chk($sformatf("v%0d led_on", i), 32'(led != 4'b0), 32'(vecs[i].led_on));
    end

    // Down count from 00:01.05: expires on exactly the 105th tick.
    mode_down = 1'b1;
    preset    = 24'h000105;
    press(4'b0100);
    chk("down entry running", 32'(running), 32'h1);
    chk("down entry time", 32'(time_bcd), 32'h000105);
    step(104);
    chk("down t104 time", 32'(time_bcd), 32'h000001);
    chk("down t104 running", 32'(running), 32'h1);
    step(1);
    chk("down t105 expired", 32'(expired), 32'h1);
    chk("down t105 time", 32'(time_bcd), 32'h0);
    step(20);
    chk("down hold expired", 32'(expired), 32'h1);
    chk("down hold time", 32'(time_bcd), 32'h0);
    press(4'b1000);
    step(3);

    // Up count for one minute, then pause and hold.
    mode_down = 1'b0;
    preset    = '0;
    press(4'b0100);
    chk("up entry time", 32'(time_bcd), 32'h0);
    step(6000);
    chk("up 6000 time", 32'(time_bcd), 32'h010000);
    press(4'b0010);
    step(50);
    chk("pause hold time", 32'(time_bcd), 32'h010003);
    chk("pause running", 32'(running), 32'h0);
    chk("pause led", 32'(led), 32'h4);
    press(4'b1000);
    step(3);

    // Reach 99:59.99 via a down preset, then wrap in up mode.
    mode_down = 1'b1;
    preset    = 24'h995999;
    press(4'b0100);
    chk("wrap preload", 32'(time_bcd), 32'h995999);
    step(3);
    press(4'b0100);
    step(3);
    chk("wrap held", 32'(time_bcd), 32'h995993);
    mode_down = 1'b0;
    press(4'b0100);
    step(6);
    chk("wrap max", 32'(time_bcd), 32'h995999);
    step(1);
    chk("wrap zero", 32'(time_bcd), 32'h0);
    chk("wrap running", 32'(running), 32'h1);
    press(4'b1000);
    step(3);

    // Laps at 10, 20 and 30 centiseconds into depth 2.
    press(4'b0100);
    step(8);
    press(4'b0001);
    step(7);
    press(4'b0001);
    step(7);
    press(4'b0001);
    chk("lap count", 32'(lap_count), 32'h2);
    chk("lap full", 32'(lap_full), 32'h1);
    lap_rd_idx = 4'd0;
    #1;
    chk("lap entry0", 32'(lap_rd_data), 32'h000010);
    lap_rd_idx = 4'd1;
    #1;
    chk("lap entry1", 32'(lap_rd_data), 32'h000020);
    lap_rd_idx = 4'd2;
    #1;
    chk("lap entry2", 32'(lap_rd_data), 32'h0);
    step(3);

    // Clear and start together while running.
    press(4'b1100);
    step(3);
    chk("clr+start running", 32'(running), 32'h0);
    chk("clr+start time", 32'(time_bcd), 32'h0);
    chk("clr+start lap_count", 32'(lap_count), 32'h0);
    chk("clr+start lap_full", 32'(lap_full), 32'h0);

    // Reset mid-run with start held across release.
    press(4'b0100);
    step(3);
    press(4'b0001);
    chk("pre-reset lap_count", 32'(lap_count), 32'h1);
    step(5);
    reset = 1'b0;
    #1;
    chk("midrst time", 32'(time_bcd), 32'h0);
    chk("midrst running", 32'(running), 32'h0);
    chk("midrst led", 32'(led), 32'h0);
    chk("midrst lap_count", 32'(lap_count), 32'h0);
    btn_start = 1'b1;
    #2;
    reset = 1'b1;
    step(10);
    chk("held start no pulse", 32'(running), 32'h0);
    btn_start = 1'b0;
    step(4);
    press(4'b0100);
    chk("fresh start", 32'(running), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
